// File: rtl/axi_lite_arbiter_2to1.sv
// Round-robin 2:1 AXI-Lite arbiter: two masters share one AXI-Lite slave with a
// single outstanding transaction; a registered grant steers the muxes.
module axi_lite_arbiter_2to1 #(
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned DATA_W = 32,
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [2*ADDR_W-1:0]   s_awaddr,
  input  logic [5:0]            s_awprot,
  input  logic [1:0]            s_awvalid,
  output logic [1:0]            s_awready,
  input  logic [2*DATA_W-1:0]   s_wdata,
  input  logic [2*STRB_W-1:0]   s_wstrb,
  input  logic [1:0]            s_wvalid,
  output logic [1:0]            s_wready,
  output logic [3:0]            s_bresp,
  output logic [1:0]            s_bvalid,
  input  logic [1:0]            s_bready,
  input  logic [2*ADDR_W-1:0]   s_araddr,
  input  logic [5:0]            s_arprot,
  input  logic [1:0]            s_arvalid,
  output logic [1:0]            s_arready,
  output logic [2*DATA_W-1:0]   s_rdata,
  output logic [3:0]            s_rresp,
  output logic [1:0]            s_rvalid,
  input  logic [1:0]            s_rready,
  output logic [ADDR_W-1:0]     m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [STRB_W-1:0]     m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_W-1:0]     m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_W-1:0]     m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  output logic                  grant,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_ADDR = 3'd3,
    WR_RESP = 3'd4
  } state_e;

  state_e     state_q;
  logic       grant_q;
  logic       last_grant_q;
  logic       aw_done_q;
  logic       w_done_q;
  logic [1:0] req_c;
  logic       winner_c;
  logic       ar_hs_c;
  logic       r_hs_c;
  logic       aw_hs_c;
  logic       w_hs_c;
  logic       b_hs_c;

  assign req_c = s_arvalid | s_awvalid;

  // On a tie the master that did not win last time goes first.
  always_comb begin
    if (req_c == 2'b11) winner_c = ~last_grant_q;
    else                winner_c = req_c[1];
  end

  assign ar_hs_c = m_arvalid & m_arready;
  assign r_hs_c  = m_rvalid  & m_rready;
  assign aw_hs_c = m_awvalid & m_awready;
  assign w_hs_c  = m_wvalid  & m_wready;
  assign b_hs_c  = m_bvalid  & m_bready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_c) begin
            grant_q      <= winner_c;
            last_grant_q <= winner_c;
            state_q      <= s_arvalid[winner_c] ? RD_ADDR : WR_ADDR;
          end
        end
        RD_ADDR: if (ar_hs_c) state_q <= RD_DATA;
        RD_DATA: if (r_hs_c)  state_q <= IDLE;
        WR_ADDR: begin
          if (aw_hs_c) aw_done_q <= 1'b1;
          if (w_hs_c)  w_done_q  <= 1'b1;
          if ((aw_done_q | aw_hs_c) & (w_done_q | w_hs_c)) state_q <= WR_RESP;
        end
        WR_RESP: begin
          if (b_hs_c) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake steering; completed write channels are masked until the response.
  always_comb begin
    s_awready = 2'b00;
    s_wready  = 2'b00;
    s_bvalid  = 2'b00;
    s_arready = 2'b00;
    s_rvalid  = 2'b00;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    case (state_q)
      RD_ADDR: begin
        m_arvalid          = s_arvalid[grant_q];
        s_arready[grant_q] = m_arready;
      end
      RD_DATA: begin
        s_rvalid[grant_q] = m_rvalid;
        m_rready          = s_rready[grant_q];
      end
      WR_ADDR: begin
        m_awvalid          = s_awvalid[grant_q] & ~aw_done_q;
        s_awready[grant_q] = m_awready & ~aw_done_q;
        m_wvalid           = s_wvalid[grant_q] & ~w_done_q;
        s_wready[grant_q]  = m_wready & ~w_done_q;
      end
      WR_RESP: begin
        s_bvalid[grant_q] = m_bvalid;
        m_bready          = s_bready[grant_q];
      end
      default: ;
    endcase
  end

  assign m_awaddr = grant_q ? s_awaddr[2*ADDR_W-1:ADDR_W] : s_awaddr[ADDR_W-1:0];
  assign m_awprot = grant_q ? s_awprot[5:3] : s_awprot[2:0];
  assign m_wdata  = grant_q ? s_wdata[2*DATA_W-1:DATA_W] : s_wdata[DATA_W-1:0];
  assign m_wstrb  = grant_q ? s_wstrb[2*STRB_W-1:STRB_W] : s_wstrb[STRB_W-1:0];
  assign m_araddr = grant_q ? s_araddr[2*ADDR_W-1:ADDR_W] : s_araddr[ADDR_W-1:0];
  assign m_arprot = grant_q ? s_arprot[5:3] : s_arprot[2:0];

  assign s_rdata = {2{m_rdata}};
  assign s_rresp = {2{m_rresp}};
  assign s_bresp = {2{m_bresp}};

  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

endmodule
